// File: rtl/onchip_ram_pipelined_pkg.sv
// Shared types and helpers for the pipelined on-chip RAM slave.
// Clear sequencer option: ONCHIP_RAM_CLEAR_EN.
package onchip_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } clr_state_t;

   localparam int RL_SHORT = 1;
   localparam int RL_LONG  = 2;

   // Width of a word index into a DEPTH-entry array (at least one bit).
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic bit addr_width_ok(input int aw, input int depth);
      return aw >= $clog2(depth);
   endfunction

endpackage

// File: rtl/onchip_ram_pipelined_if.sv
// Avalon-MM slave bus bundle for onchip_ram_pipelined, with enable/freeze controls.
interface onchip_ram_pipelined_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14
);
   logic [ADDR_WIDTH-1:0]   address;
   logic [DATA_WIDTH/8-1:0] byteenable;
   logic                    chipselect;
   logic                    read;
   logic                    write;
   logic [DATA_WIDTH-1:0]   writedata;
   logic                    clken;
   logic                    reset_req;
   logic [DATA_WIDTH-1:0]   readdata;
   logic                    readdatavalid;
   logic                    waitrequest;

   modport master (
      output address, byteenable, chipselect, read, write, writedata, clken, reset_req,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, byteenable, chipselect, read, write, writedata, clken, reset_req,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/onchip_ram_pipelined_clear_seq.sv
// Post-reset clear sequencer: walks every word address once, writing zero, then idles.
// Only instantiated when ONCHIP_RAM_CLEAR_EN is defined.
module onchip_ram_clear_seq
   import onchip_ram_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   output logic             o_clearing,
   output logic [IDX_W-1:0] o_clr_addr,
   output logic             o_clr_we
);
   clr_state_t       r_state, w_state_next;
   logic [IDX_W-1:0] r_cnt, w_cnt_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      o_clearing   = 1'b0;
      o_clr_we     = 1'b0;
      case (r_state)
         CLEAR: begin
            o_clearing = 1'b1;
            o_clr_we   = i_en;
            if (i_en) begin
               if (r_cnt == IDX_W'(DEPTH - 1)) begin
                  w_state_next = READY;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         READY:   ;
         default: w_state_next = CLEAR;
      endcase
   end

   assign o_clr_addr = r_cnt;
endmodule

// File: rtl/onchip_ram_pipelined.sv
// Parametrised Avalon-MM single-port RAM with pipelined reads and clock-enable freeze.
// Optional post-reset zero fill: ONCHIP_RAM_CLEAR_EN.
module onchip_ram_pipelined
   import onchip_ram_pkg::*;
#(
   parameter int    DATA_WIDTH   = 32,
   parameter int    DEPTH        = 10240,
   parameter int    ADDR_WIDTH   = 14,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = ""
) (
   input logic                  clk,
   input logic                  reset,
   onchip_ram_pipelined_if.slave bus
);
   localparam int LANES = DATA_WIDTH / 8;
   localparam int IDX_W = idx_width(DEPTH);

   if (READ_LATENCY != RL_SHORT && READ_LATENCY != RL_LONG) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of 8");
   end
   if (!addr_width_ok(ADDR_WIDTH, DEPTH)) begin : g_bad_addr
      $error("ADDR_WIDTH too narrow for DEPTH");
   end

   logic                  w_en, w_clearing, w_accept, w_in_range;
   logic                  w_wr_fire, w_rd_fire, w_clr_we;
   logic [IDX_W-1:0]      w_idx, w_clr_addr, w_wr_addr;
   logic [LANES-1:0]      w_lane_we;
   logic [DATA_WIDTH-1:0] w_wr_data, w_s1_data, w_out_data;
   logic                  w_out_vld;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_q;
   logic                  r_s1_vld, r_s1_zero;

   assign w_en       = bus.clken & ~bus.reset_req;
   assign w_accept   = bus.chipselect & ~bus.waitrequest;
   assign w_in_range = 32'(bus.address) < DEPTH;
   assign w_idx      = bus.address[IDX_W-1:0];
   assign w_wr_fire  = w_accept & bus.write & w_in_range;
   assign w_rd_fire  = w_accept & bus.read & ~bus.write;

`ifdef ONCHIP_RAM_CLEAR_EN
   onchip_ram_clear_seq #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_clear_seq (
      .clk        (clk),
      .reset      (reset),
      .i_en       (w_en),
      .o_clearing (w_clearing),
      .o_clr_addr (w_clr_addr),
      .o_clr_we   (w_clr_we)
   );
`else
   assign w_clearing = 1'b0;
   assign w_clr_addr = '0;
   assign w_clr_we   = 1'b0;
`endif

   // The clear sequencer owns the write port while it runs; bus commands are stalled then.
   assign w_wr_addr = w_clr_we ? w_clr_addr : w_idx;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_we[gi]          = w_clr_we | (w_wr_fire & bus.byteenable[gi]);
      assign w_wr_data[8*gi +: 8]   = w_clr_we ? 8'h00 : bus.writedata[8*gi +: 8];
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (w_lane_we[i]) r_mem[w_wr_addr][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (w_rd_fire) r_q <= r_mem[w_idx];
   end

   // r_q has no reset (block RAM output); a resettable flag masks it to zero instead,
   // which also yields the all-zero result for out-of-range reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_vld  <= 1'b0;
         r_s1_zero <= 1'b1;
      end else if (w_en) begin
         r_s1_vld <= w_rd_fire;
         if (w_rd_fire) r_s1_zero <= ~w_in_range;
      end
   end

   assign w_s1_data = r_s1_zero ? '0 : r_q;

   if (READ_LATENCY == RL_LONG) begin : g_rl2
      logic [DATA_WIDTH-1:0] r_s2_data;
      logic                  r_s2_vld;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_s2_data <= '0;
            r_s2_vld  <= 1'b0;
         end else if (w_en) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) r_s2_data <= w_s1_data;
         end
      end

      assign w_out_data = r_s2_data;
      assign w_out_vld  = r_s2_vld;
   end else begin : g_rl1
      assign w_out_data = w_s1_data;
      assign w_out_vld  = r_s1_vld;
   end

   assign bus.readdata      = w_out_data;
   assign bus.readdatavalid = w_out_vld & w_en;
   assign bus.waitrequest   = ~w_en | w_clearing;
endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Bench for onchip_ram_pipelined: latency-1 and latency-2 instances share one stimulus stream.
// Honours ONCHIP_RAM_CLEAR_EN for the clear-sequencer checks.
module tb_onchip_ram_pipelined;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 5;

   logic clk;
   logic reset;

   onchip_ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
   onchip_ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

   assign bus2.address    = bus1.address;
   assign bus2.byteenable = bus1.byteenable;
   assign bus2.chipselect = bus1.chipselect;
   assign bus2.read       = bus1.read;
   assign bus2.write      = bus1.write;
   assign bus2.writedata  = bus1.writedata;
   assign bus2.clken      = bus1.clken;
   assign bus2.reset_req  = bus1.reset_req;

   onchip_ram_pipelined #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_FILE(""))
      u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
   onchip_ram_pipelined #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_FILE(""))
      u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int v_cnt1  = 0;
   int v_cnt2  = 0;
   logic [31:0] q1[$];
   logic [31:0] q2[$];
   logic [31:0] model [DEPTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every valid must match the oldest outstanding read of that instance.
   always @(negedge clk) begin
      if (bus1.readdatavalid === 1'b1) begin
         v_cnt1++;
         chk_b("rl1_valid_expected", q1.size() > 0, 1'b1);
         if (q1.size() > 0) chk("rl1_data", bus1.readdata, q1.pop_front());
      end
      if (bus2.readdatavalid === 1'b1) begin
         v_cnt2++;
         chk_b("rl2_valid_expected", q2.size() > 0, 1'b1);
         if (q2.size() > 0) chk("rl2_data", bus2.readdata, q2.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus1.chipselect = 1'b0;
      bus1.read       = 1'b0;
      bus1.write      = 1'b0;
   endtask

   task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      if (a < DEPTH) begin
         for (int l = 0; l < 4; l++) if (be[l]) model[a][8*l +: 8] = d[8*l +: 8];
      end
   endtask

   task automatic drive_read(input logic [AW-1:0] a);
      logic [31:0] e;
      e = (a < DEPTH) ? model[a] : 32'h0;
      bus1.address    = a;
      bus1.chipselect = 1'b1;
      bus1.read       = 1'b1;
      bus1.write      = 1'b0;
      q1.push_back(e);
      q2.push_back(e);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      bus1.address    = a;
      bus1.writedata  = d;
      bus1.byteenable = be;
      bus1.chipselect = 1'b1;
      bus1.write      = 1'b1;
      bus1.read       = 1'b0;
      model_write(a, d, be);
      tick();
      idle();
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      drive_read(a);
      tick();
      idle();
   endtask

   task automatic count_clear(output int c);
      c = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus1.waitrequest === 1'b1) c++;
         else break;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int c, s1, s2;
      reset           = 1'b1;
      bus1.clken      = 1'b1;
      bus1.reset_req  = 1'b0;
      bus1.address    = '0;
      bus1.writedata  = '0;
      bus1.byteenable = '0;
      idle();
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      repeat (2) tick();

      @(negedge clk);
      chk("reset_rdata_rl1", bus1.readdata, 32'h0);
      chk("reset_rdata_rl2", bus2.readdata, 32'h0);
      chk_b("reset_valid_rl1", bus1.readdatavalid, 1'b0);
      chk_b("reset_valid_rl2", bus2.readdatavalid, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;

`ifdef ONCHIP_RAM_CLEAR_EN
      count_clear(c);
      chk("clear_cycles", 32'(c), 32'd16);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (8) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      count_clear(c);
      chk("clear_restart_cycles", 32'(c), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         drive_read(AW'(i));
         tick();
      end
      idle();
      repeat (3) tick();
`else
      @(negedge clk);
      chk_b("ready_after_reset", bus1.waitrequest, 1'b0);
      @(posedge clk);
      #1;
`endif

      for (int i = 0; i < 8; i++) do_write(AW'(i), 32'hC0DE_0000 + 32'(i * 17), 4'hF);
      do_write(AW'(DEPTH - 1), 32'hF00D_F00F, 4'hF);

      // Byte-enable merge and latency of each instance
      do_write(5'd5, 32'hAABB_CCDD, 4'hF);
      do_write(5'd5, 32'h1122_3344, 4'b0101);
      drive_read(5'd5);
      tick();
      idle();
      chk_b("be_rl1_valid", bus1.readdatavalid, 1'b1);
      chk("be_rl1_data", bus1.readdata, 32'hAA22_CC44);
      chk_b("be_rl2_not_yet", bus2.readdatavalid, 1'b0);
      tick();
      chk_b("be_rl2_valid", bus2.readdatavalid, 1'b1);
      chk("be_rl2_data", bus2.readdata, 32'hAA22_CC44);
      chk_b("be_rl1_single", bus1.readdatavalid, 1'b0);
      tick();
      chk("rl1_hold", bus1.readdata, 32'hAA22_CC44);
      chk("rl2_hold", bus2.readdata, 32'hAA22_CC44);

      // Streaming: back-to-back reads give back-to-back valids
      for (int i = 0; i < 8; i++) begin
         drive_read(AW'(i));
         tick();
         chk_b("stream_rl1_valid", bus1.readdatavalid, 1'b1);
         chk_b("stream_rl2_valid", bus2.readdatavalid, i > 0);
      end
      idle();
      tick();
      chk_b("stream_rl1_end", bus1.readdatavalid, 1'b0);
      chk_b("stream_rl2_last", bus2.readdatavalid, 1'b1);
      tick();
      chk_b("stream_rl2_end", bus2.readdatavalid, 1'b0);

      // Freeze with a read in flight
      s1 = v_cnt1;
      s2 = v_cnt2;
      drive_read(5'd3);
      tick();
      idle();
      bus1.clken = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_b("freeze_waitreq", bus1.waitrequest, 1'b1);
         chk_b("freeze_rl1_valid", bus1.readdatavalid, 1'b0);
         chk_b("freeze_rl2_valid", bus2.readdatavalid, 1'b0);
         @(posedge clk);
         #1;
      end
      bus1.clken = 1'b1;
      repeat (4) tick();
      chk("freeze_rl1_once", 32'(v_cnt1 - s1), 32'd1);
      chk("freeze_rl2_once", 32'(v_cnt2 - s2), 32'd1);

      bus1.reset_req = 1'b1;
      #1;
      chk_b("reset_req_waitreq", bus1.waitrequest, 1'b1);
      bus1.reset_req = 1'b0;
      #1;
      chk_b("reset_req_release", bus1.waitrequest, 1'b0);

      // Boundaries
      do_write(AW'(DEPTH), 32'hDEAD_BEEF, 4'hF);
      do_read(5'd0);
      do_read(AW'(DEPTH));
      do_read(AW'(DEPTH - 1));
      repeat (3) tick();
      s1 = v_cnt1;
      s2 = v_cnt2;
      bus1.address    = 5'd2;
      bus1.writedata  = 32'h5555_AAAA;
      bus1.byteenable = 4'hF;
      bus1.chipselect = 1'b1;
      bus1.read       = 1'b1;
      bus1.write      = 1'b1;
      model_write(5'd2, 32'h5555_AAAA, 4'hF);
      tick();
      idle();
      repeat (3) tick();
      chk("rdwr_no_valid_rl1", 32'(v_cnt1 - s1), 32'd0);
      chk("rdwr_no_valid_rl2", 32'(v_cnt2 - s2), 32'd0);
      do_read(5'd2);
      repeat (3) tick();

      // Reset with a latency-2 read in flight
      drive_read(5'd7);
      tick();
      idle();
      reset = 1'b1;
      #1;
      q1.delete();
      q2.delete();
      chk("rst_rdata_rl1", bus1.readdata, 32'h0);
      chk("rst_rdata_rl2", bus2.readdata, 32'h0);
      chk_b("rst_valid_rl2", bus2.readdatavalid, 1'b0);
      s1 = v_cnt1;
      s2 = v_cnt2;
      tick();
      reset = 1'b0;
`ifdef ONCHIP_RAM_CLEAR_EN
      count_clear(c);
      chk("clear_after_rst_cycles", 32'(c), 32'd16);
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
`else
      repeat (3) tick();
`endif
      chk("rst_no_valid_rl1", 32'(v_cnt1 - s1), 32'd0);
      chk("rst_no_valid_rl2", 32'(v_cnt2 - s2), 32'd0);
      drive_read(5'd7);
      tick();
      idle();
      chk("rst_preserved_rl1", bus1.readdata, model[7]);
      repeat (4) tick();

      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
